// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the multiplexer scan controller.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_VALID  = 2'd3
    } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between the scan controller and its requester / multiplexer / consumer.
// With MUX_SCAN_PARITY_EN defined the bundle also carries data_par.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              start;
    logic              abort;
    logic              mux_en_n;
    logic [ADDR_W-1:0] mux_addr;
    logic              mux_out;
    logic [NUM_CH-1:0] data;
    logic              data_valid;
    logic              data_ready;
    logic              busy;
`ifdef MUX_SCAN_PARITY_EN
    logic              data_par;

    modport master (
        output start, abort, mux_out, data_ready,
        input  mux_en_n, mux_addr, data, data_valid, busy, data_par
    );
    modport slave (
        input  start, abort, mux_out, data_ready,
        output mux_en_n, mux_addr, data, data_valid, busy, data_par
    );
`else
    modport master (
        output start, abort, mux_out, data_ready,
        input  mux_en_n, mux_addr, data, data_valid, busy
    );
    modport slave (
        input  start, abort, mux_out, data_ready,
        output mux_en_n, mux_addr, data, data_valid, busy
    );
`endif

endinterface

// File: rtl/mux_scan_timer.sv
// Settle down-counter: loaded on entry to a channel step, expired during its final settle cycle.
module mux_scan_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    // A load of N gives exactly N settle cycles: the last one sees count==1.
    assign expired = (count <= CNT_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans an external 8:1 multiplexer channel by channel and presents the assembled word with a valid/ready handshake.
// Optional MUX_SCAN_PARITY_EN adds data_par, the XOR of all data bits, registered with data.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic            clk,
    input logic            rst_n,
    mux_scan_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_CH   = ADDR_W'(NUM_CH - 1);
    localparam state_e            STEP_ST   = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

    state_e            state;
    logic              mux_en_n;
    logic [ADDR_W-1:0] mux_addr;
    logic [NUM_CH-1:0] data;
    logic              data_valid;
    logic              busy;

    logic              begin_scan_c;
    logic              settle_load_c;
    logic              settle_expired_c;

    // New scan accepted from IDLE, or from VALID on the handshake edge; abort always wins.
    always_comb begin
        begin_scan_c  = 1'b0;
        settle_load_c = 1'b0;
        if (!bus.abort) begin
            begin_scan_c  = bus.start &&
                            ((state == ST_IDLE) || ((state == ST_VALID) && bus.data_ready));
            settle_load_c = begin_scan_c || ((state == ST_SAMPLE) && (mux_addr != LAST_CH));
        end
    end

    mux_scan_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (settle_load_c),
        .value   (SETTLE_LD),
        .expired (settle_expired_c)
    );

`ifdef MUX_SCAN_PARITY_EN
    logic              data_par;
    logic [NUM_CH-1:0] sampled_c;

    always_comb begin
        sampled_c           = data;
        sampled_c[mux_addr] = bus.mux_out;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mux_en_n   <= 1'b1;
            mux_addr   <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            data_par   <= 1'b0;
`endif
        end else if (bus.abort) begin
            state      <= ST_IDLE;
            mux_en_n   <= 1'b1;
            mux_addr   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else if (begin_scan_c) begin
            state      <= STEP_ST;
            mux_en_n   <= 1'b0;
            mux_addr   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (settle_expired_c) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    data[mux_addr] <= bus.mux_out;
`ifdef MUX_SCAN_PARITY_EN
                    data_par       <= ^sampled_c;
`endif
                    if (mux_addr == LAST_CH) begin
                        state      <= ST_VALID;
                        mux_en_n   <= 1'b1;
                        data_valid <= 1'b1;
                    end else begin
                        mux_addr <= mux_addr + ADDR_W'(1);
                        state    <= STEP_ST;
                    end
                end
                ST_VALID: begin
                    if (bus.data_ready) begin
                        state      <= ST_IDLE;
                        data_valid <= 1'b0;
                        mux_addr   <= '0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mux_en_n   = mux_en_n;
    assign bus.mux_addr   = mux_addr;
    assign bus.data       = data;
    assign bus.data_valid = data_valid;
    assign bus.busy       = busy;
`ifdef MUX_SCAN_PARITY_EN
    assign bus.data_par   = data_par;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with SETTLE_CYCLES=1 and one with 0, checked against a cycle-count model.
// Parity checks are active when MUX_SCAN_PARITY_EN is defined.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       start, abort, ready;
    logic [7:0] pat;
    logic [7:0] model_data [2];
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl_if if1 ();
    mux_scan_ctrl_if if0 ();

    assign if1.start      = sel & start;
    assign if1.abort      = sel & abort;
    assign if1.data_ready = sel & ready;
    assign if1.mux_out    = pat[if1.mux_addr];
    assign if0.start      = ~sel & start;
    assign if0.abort      = ~sel & abort;
    assign if0.data_ready = ~sel & ready;
    assign if0.mux_out    = pat[if0.mux_addr];

    mux_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mux_scan_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    wire       en_n_o  = sel ? if1.mux_en_n   : if0.mux_en_n;
    wire [2:0] addr_o  = sel ? if1.mux_addr   : if0.mux_addr;
    wire [7:0] data_o  = sel ? if1.data       : if0.data;
    wire       valid_o = sel ? if1.data_valid : if0.data_valid;
    wire       busy_o  = sel ? if1.busy       : if0.busy;
`ifdef MUX_SCAN_PARITY_EN
    wire       par_o   = sel ? if1.data_par   : if0.data_par;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Quiet outputs expected in IDLE (after reset, abort or a plain handshake).
    task automatic check_idle(input string tag, input logic [7:0] exp_data);
        if (en_n_o !== 1'b1) $display("FAIL %s_en_n: got %b want 1", tag, en_n_o); else passes++;
        checks++;
        if (addr_o !== 3'd0) $display("FAIL %s_addr: got %0d want 0", tag, addr_o); else passes++;
        checks++;
        if (valid_o !== 1'b0) $display("FAIL %s_valid: got %b want 0", tag, valid_o); else passes++;
        checks++;
        if (busy_o !== 1'b0) $display("FAIL %s_busy: got %b want 0", tag, busy_o); else passes++;
        checks++;
        if (data_o !== exp_data) $display("FAIL %s_data: got %h want %h", tag, data_o, exp_data); else passes++;
        checks++;
    endtask

    // One complete scan started in cycle 0; hold = cycles data_ready stays low once valid.
    task automatic run_scan(input logic s, input logic [7:0] p, input int hold, input bit noise);
        int v;
        v = 8 * (int'(s) + 1) + 1;
        sel = s; pat = p; abort = 1'b0; start = 1'b1; ready = (hold == 0);
        for (int t = 1; t < v; t++) begin
            tick();
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) ready = 1'($urandom_range(0, 1));
            if (en_n_o !== 1'b0) $display("FAIL scan_en_n: s=%0d t=%0d got %b want 0", s, t, en_n_o); else passes++;
            checks++;
            if (addr_o !== 3'((t - 1) / (int'(s) + 1)))
                $display("FAIL scan_addr: s=%0d t=%0d got %0d want %0d", s, t, addr_o, (t - 1) / (int'(s) + 1));
            else passes++;
            checks++;
            if (valid_o !== 1'b0) $display("FAIL scan_early_valid: s=%0d t=%0d got %b want 0", s, t, valid_o); else passes++;
            checks++;
            if (busy_o !== 1'b1) $display("FAIL scan_busy: s=%0d t=%0d got %b want 1", s, t, busy_o); else passes++;
            checks++;
        end
        tick();
        start = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (valid_o !== 1'b1) $display("FAIL valid_hold: s=%0d h=%0d got %b want 1", s, h, valid_o); else passes++;
            checks++;
            if (data_o !== p) $display("FAIL data_hold: s=%0d h=%0d got %h want %h", s, h, data_o, p); else passes++;
            checks++;
            if (addr_o !== 3'd7) $display("FAIL valid_addr: s=%0d got %0d want 7", s, addr_o); else passes++;
            checks++;
            if (en_n_o !== 1'b1 || busy_o !== 1'b1)
                $display("FAIL valid_en_busy: s=%0d got en_n=%b busy=%b want 1 1", s, en_n_o, busy_o);
            else passes++;
            checks++;
`ifdef MUX_SCAN_PARITY_EN
            if (par_o !== ^p) $display("FAIL data_par: s=%0d got %b want %b", s, par_o, ^p); else passes++;
            checks++;
`endif
            ready = (h == hold);
            tick();
        end
        ready = 1'b0;
        model_data[s] = p;
        check_idle("after_handshake", p);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; pat = 8'h00; sel = 1'b1;
        model_data[0] = 8'h00; model_data[1] = 8'h00;
        #12;
        for (int k = 0; k < 2; k++) begin
            sel = 1'(k);
            #1;
            check_idle("reset", 8'h00);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_scans();
        run_scan(1'b1, 8'hA5, 0, 1'b0);
        run_scan(1'b0, 8'h3C, 5, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_scan(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 4)), 1'b1);
            repeat (int'($urandom_range(0, 2))) tick();
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b1; pat = 8'hFF; start = 1'b1; ready = 1'b1; abort = 1'b0;
        repeat (17) tick();
        if (valid_o !== 1'b1 || data_o !== 8'hFF)
            $display("FAIL b2b_first: got valid=%b data=%h want 1 ff", valid_o, data_o);
        else passes++;
        checks++;
        pat = 8'h00;
        tick();
        if (valid_o !== 1'b0 || en_n_o !== 1'b0 || addr_o !== 3'd0 || busy_o !== 1'b1)
            $display("FAIL b2b_restart: got valid=%b en_n=%b addr=%0d busy=%b want 0 0 0 1",
                     valid_o, en_n_o, addr_o, busy_o);
        else passes++;
        checks++;
        repeat (15) tick();
        if (valid_o !== 1'b0) $display("FAIL b2b_early: got %b want 0", valid_o); else passes++;
        checks++;
        tick();
        if (valid_o !== 1'b1 || data_o !== 8'h00)
            $display("FAIL b2b_second: got valid=%b data=%h want 1 00", valid_o, data_o);
        else passes++;
        checks++;
        start = 1'b0;
        tick();
        ready = 1'b0;
        model_data[1] = 8'h00;
        check_idle("b2b_end", 8'h00);
    endtask

    task automatic test_abort();
        logic [7:0] p;
        logic [7:0] exp;
        p = 8'($urandom);
        sel = 1'b1; pat = p; start = 1'b1; ready = 1'b1; abort = 1'b0;
        tick();
        start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        // Channels 0 and 1 were sampled in cycles 2 and 4; the channel 2 sample is cancelled.
        exp = (model_data[1] & 8'hFC) | (p & 8'h03);
        check_idle("abort", exp);
        start = 1'b1;
        tick();
        check_idle("abort_over_start", exp);
        start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check_idle("abort_quiet", exp);
        model_data[1] = exp;
        run_scan(1'b1, 8'($urandom), 0, 1'b0);
    endtask

    task automatic test_async_reset();
        sel = 1'b1; pat = 8'h07; start = 1'b1; ready = 1'b0; abort = 1'b0;
        repeat (4) tick();
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_reset", 8'h00);
`ifdef MUX_SCAN_PARITY_EN
        if (par_o !== 1'b0) $display("FAIL reset_par: got %b want 0", par_o); else passes++;
        checks++;
`endif
        model_data[0] = 8'h00; model_data[1] = 8'h00;
        #2 rst_n = 1'b1;
        repeat (3) tick();
        check_idle("no_auto_start", 8'h00);
        run_scan(1'b1, 8'h07, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_scans();
        test_random();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SETTLE_CYCLES, default 1, number of settle cycles after each address change before sampling (legal range 0..15).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request one 8-channel scan; sampled only in IDLE.
REQ-005 abort  input  1  synchronous scan cancel; highest priority.
REQ-006 mux_en_n  output  1  active-low enable to the downstream 8:1 multiplexer.
REQ-007 mux_addr  output  3  channel select to the multiplexer.
REQ-008 mux_out  input  1  selected bit returned by the multiplexer.
REQ-009 data  output  8  assembled word; bit c holds the channel c sample.
REQ-010 data_valid  output  1  data holds a complete scan.
REQ-011 data_ready  input  1  consumer accepts data when data_valid is high.
REQ-012 busy  output  1  high in SETTLE, SAMPLE and VALID.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, SAMPLE and VALID; all outputs are registered.
REQ-014 IDLE with start=1: next state SETTLE (SAMPLE if SETTLE_CYCLES=0), mux_addr=0, mux_en_n=0, settle counter loaded with SETTLE_CYCLES.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-016 SAMPLE SHALL last one cycle and write mux_out into data[mux_addr] at its closing edge.
REQ-017 SAMPLE with mux_addr<7: mux_addr increments by 1, and the FSM returns to SETTLE (SAMPLE directly if SETTLE_CYCLES=0).
REQ-018 SAMPLE with mux_addr=7: next state VALID, mux_en_n=1, data_valid=1; mux_addr does not wrap while leaving SAMPLE.
REQ-019 Latency: with start accepted in cycle 0, channel c is sampled in cycle (c+1)*(SETTLE_CYCLES+1), and data_valid is first high in cycle 8*(SETTLE_CYCLES+1)+1 (cycle 17 when SETTLE_CYCLES=1).
REQ-020 mux_en_n SHALL be 0 only in SETTLE and SAMPLE.
REQ-021 In VALID, data and data_valid SHALL hold stable until data_valid and data_ready are high in the same cycle.
REQ-022 Handshake edge in VALID: data_valid falls; if start=1 in that cycle, the FSM enters SETTLE/SAMPLE as in REQ-014, otherwise it enters IDLE with mux_addr=0.
REQ-023 start SHALL be ignored in SETTLE and SAMPLE.
REQ-024 abort=1 in any state: next state IDLE, mux_en_n=1, mux_addr=0, data_valid=0, data unchanged; abort overrides start and the handshake.
REQ-025 data_ready SHALL be ignored outside VALID.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, mux_en_n=1, mux_addr=0, data=0, data_valid=0, busy=0 and settle counter 0, including mid-scan.
REQ-027 The first scan after reset deassertion SHALL require a fresh start.

Configuration
REQ-028 With MUX_SCAN_PARITY_EN defined, output data_par (1 bit) SHALL equal the XOR of all data bits.
- data_par is registered with data and valid with data_valid.
- data_par resets to 0.
REQ-029 Without MUX_SCAN_PARITY_EN, the data_par port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package mux_scan_pkg SHALL hold:
- the state enum;
- NUM_CH=8;
- ADDR_W=3;
- settle counter width 4.
REQ-031 The settle down-counter SHALL be one sub-module, mux_scan_timer, with load/value/expired ports; all other logic is flat.

Verification
REQ-032 SETTLE_CYCLES=1, mux_out driven from pattern 8'hA5 by mux_addr, start pulse in cycle 0, data_ready=1 -> data_valid high in cycle 17 with data=8'hA5 and mux_en_n low in cycles 1..16 only.
REQ-033 SETTLE_CYCLES=0, pattern 8'h3C, data_ready held 0 for 5 cycles -> data_valid high in cycle 9, data=8'h3C held stable until the handshake, then IDLE.
REQ-034 start=1 held continuously, pattern 8'hFF then 8'h00 -> back-to-back scans, second scan begins on the handshake edge, data=8'h00 on the second valid.
REQ-035 abort pulse in cycle 6 of a SETTLE_CYCLES=1 scan -> IDLE next cycle, mux_en_n=1, mux_addr=0, data_valid stays 0; a later start completes normally.
REQ-036 rst_n pulled low asynchronously mid-SAMPLE -> outputs take their REQ-026 values before the next clock edge; with MUX_SCAN_PARITY_EN defined, pattern 8'h07 gives data_par=1.
